// File: rtl/kernel_invoker_pkg.sv
// rtl/kernel_invoker_pkg.sv - shared types and default widths for the kernel invoker
package kernel_invoker_pkg;

    localparam int DEF_ARG_W = 32;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SETTLE,
        WAIT,
        PUSH
    } state_t;

    typedef struct packed {
        logic [DEF_ARG_W-1:0] result;
        logic                 timeout;
        logic [DEF_CNT_W-1:0] cycles;
    } rsp_entry_t;

endpackage

// File: rtl/invoker_rsp_fifo.sv
// rtl/invoker_rsp_fifo.sv - synchronous response FIFO, push allowed when full if popping same cycle
module invoker_rsp_fifo #(
    parameter int DATA_W = 49,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              push, pop;

    always_comb begin
        rd_valid = (count_q != '0);
        wr_ready = (count_q != DEPTH_C) || rd_ready;
        pop      = rd_valid && rd_ready;
        push     = wr_valid && wr_ready;
        rd_data  = mem_q[rd_ptr_q];
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/kernel_invoker.sv
// rtl/kernel_invoker.sv - launches a single-shot kernel per request and queues result/timeout/cycles
module kernel_invoker
    import kernel_invoker_pkg::*;
#(
    parameter int ARG_W     = DEF_ARG_W,
    parameter int TIMEOUT   = 65535,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int RSP_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ARG_W-1:0] req_n,
    input  logic [ARG_W-1:0] req_a,
    input  logic [ARG_W-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ARG_W-1:0] rsp_result,
    output logic             rsp_timeout,
    output logic [CNT_W-1:0] rsp_cycles,
    output logic             busy,
    output logic             k_r_enable,
    output logic [ARG_W-1:0] k_init_n,
    output logic [ARG_W-1:0] k_init_a,
    output logic [ARG_W-1:0] k_init_b,
    input  logic             k_w_enable,
    input  logic [ARG_W-1:0] k_result
);
    localparam int          ENTRY_W   = ARG_W + 1 + CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0]   TIMEOUT_V = (CNT_W+1)'(TIMEOUT);

    state_t           state_q, state_d;
    logic             k_r_enable_q, k_r_enable_d;
    logic             busy_q, busy_d;
    logic             req_ready_q, req_ready_d;
    logic [ARG_W-1:0] k_init_n_q, k_init_n_d, k_init_a_q, k_init_a_d, k_init_b_q, k_init_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [ARG_W-1:0] res_q, res_d;
    logic             to_q, to_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             fifo_wr_ready;
    logic [ENTRY_W-1:0] fifo_rd_data;

    always_comb begin
        state_d    = state_q;
        k_init_n_d = k_init_n_q;
        k_init_a_d = k_init_a_q;
        k_init_b_d = k_init_b_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        to_d       = to_q;
        cyc_d      = cyc_q;
        cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        case (state_q)
            IDLE: if (req_valid) begin
                k_init_n_d = req_n;
                k_init_a_d = req_a;
                k_init_b_d = req_b;
                state_d    = LAUNCH;
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                cnt_d   = cnt_inc;
                state_d = WAIT;
            end
            // cnt_inc is the count of the current cycle; done takes priority over timeout
            WAIT: begin
                cnt_d = cnt_inc;
                if (k_w_enable) begin
                    res_d   = k_result;
                    to_d    = 1'b0;
                    cyc_d   = cnt_inc;
                    state_d = PUSH;
                end else if ({1'b0, cnt_inc} >= TIMEOUT_V) begin
                    res_d   = '0;
                    to_d    = 1'b1;
                    cyc_d   = cnt_inc;
                    state_d = PUSH;
                end
            end
            PUSH: if (fifo_wr_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        k_r_enable_d = (state_d == LAUNCH);
        busy_d       = (state_d != IDLE);
        req_ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            k_r_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            req_ready_q  <= 1'b1;
            k_init_n_q   <= '0;
            k_init_a_q   <= '0;
            k_init_b_q   <= '0;
            cnt_q        <= '0;
            res_q        <= '0;
            to_q         <= 1'b0;
            cyc_q        <= '0;
        end else begin
            state_q      <= state_d;
            k_r_enable_q <= k_r_enable_d;
            busy_q       <= busy_d;
            req_ready_q  <= req_ready_d;
            k_init_n_q   <= k_init_n_d;
            k_init_a_q   <= k_init_a_d;
            k_init_b_q   <= k_init_b_d;
            cnt_q        <= cnt_d;
            res_q        <= res_d;
            to_q         <= to_d;
            cyc_q        <= cyc_d;
        end
    end

    invoker_rsp_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (state_q == PUSH),
        .wr_ready (fifo_wr_ready),
        .wr_data  ({res_q, to_q, cyc_q}),
        .rd_valid (rsp_valid),
        .rd_ready (rsp_ready),
        .rd_data  (fifo_rd_data)
    );

    assign {rsp_result, rsp_timeout, rsp_cycles} = fifo_rd_data;
    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign k_r_enable = k_r_enable_q;
    assign k_init_n   = k_init_n_q;
    assign k_init_a   = k_init_a_q;
    assign k_init_b   = k_init_b_q;

endmodule

// File: tb/tb_kernel_invoker.sv
// tb/tb_kernel_invoker.sv - directed bench for kernel_invoker with an a+b kernel model
module tb_kernel_invoker;
    localparam int ARG_W = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [ARG_W-1:0] req_n, req_a, req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [ARG_W-1:0] rsp_result;
    logic             rsp_timeout;
    logic [CNT_W-1:0] rsp_cycles;
    logic             busy;
    logic             k_r_enable;
    logic [ARG_W-1:0] k_init_n, k_init_a, k_init_b;
    logic             k_w_enable;
    logic [ARG_W-1:0] k_result;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    kernel_invoker #(
        .ARG_W     (ARG_W),
        .TIMEOUT   (8),
        .CNT_W     (CNT_W),
        .RSP_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_n       (req_n),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_timeout (rsp_timeout),
        .rsp_cycles  (rsp_cycles),
        .busy        (busy),
        .k_r_enable  (k_r_enable),
        .k_init_n    (k_init_n),
        .k_init_a    (k_init_a),
        .k_init_b    (k_init_b),
        .k_w_enable  (k_w_enable),
        .k_result    (k_result)
    );

    always #5 clk = ~clk;

    // Kernel model: done level rises n cycles after the start edge, stale level survives one cycle
    logic             never_done = 1'b0;
    logic             kw = 1'b0;
    logic             kact = 1'b0;
    int               kcnt = 0;
    logic [ARG_W-1:0] kn = '0, ka = '0, kb = '0, kres = '0;

    always @(posedge clk) begin
        if (k_r_enable) begin
            kcnt <= 0;
            kact <= 1'b1;
            kn   <= k_init_n;
            ka   <= k_init_a;
            kb   <= k_init_b;
            pulses <= pulses + 1;
        end else if (kact) begin
            kcnt <= kcnt + 1;
            kw   <= (kcnt + 1 == int'(kn)) && !never_done;
            if (kcnt + 1 == int'(kn)) begin
                kact <= 1'b0;
                kres <= ka + kb;
            end
        end
    end
    assign k_w_enable = kw;
    assign k_result   = kres;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int n, input int a, input int b);
        int k = 0;
        while (!req_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_wait", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_n = n;
        req_a = a;
        req_b = b;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input int exp_res, input int exp_to,
                           input int exp_cyc, output int waited);
        waited = 0;
        while (!rsp_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"},   64'(rsp_valid),   64'd1);
        check({tag, "_result"},  64'(rsp_result),  64'(exp_res));
        check({tag, "_timeout"}, 64'(rsp_timeout), 64'(exp_to));
        check({tag, "_cycles"},  64'(rsp_cycles),  64'(exp_cyc));
        @(negedge clk);
    endtask

    initial begin
        int w;
        int p0;
        rst = 1'b1;
        req_valid = 1'b0;
        req_n = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_k_r_enable", 64'(k_r_enable), 64'd0);
        check("reset_k_init_n", 64'(k_init_n), 64'd0);

        // single job
        p0 = pulses;
        send(3, 5, 7);
        get_rsp("t1", 12, 0, 4, w);
        check("t1_pulses", 64'(pulses - p0), 64'd1);
        check("t1_init_a_held", 64'(k_init_a), 64'd5);

        // back-to-back, stale done from job 1 must be ignored; minimum latency
        send(1, 1, 1);
        get_rsp("t2a", 2, 0, 2, w);
        check("t2a_latency", 64'(w), 64'd4);
        send(2, 10, 20);
        get_rsp("t2b", 30, 0, 3, w);

        // consumer stalled: FIFO fills, FSM holds in PUSH
        rsp_ready = 1'b0;
        send(1, 0, 1);
        send(1, 0, 2);
        send(1, 0, 3);
        repeat (8) @(negedge clk);
        check("t3_req_ready", 64'(req_ready), 64'd0);
        check("t3_busy", 64'(busy), 64'd1);
        check("t3_head", 64'(rsp_result), 64'd1);
        rsp_ready = 1'b1;
        get_rsp("t3_1", 1, 0, 2, w);
        get_rsp("t3_2", 2, 0, 2, w);
        get_rsp("t3_3", 3, 0, 2, w);
        check("t3_drained", 64'(rsp_valid), 64'd0);
        check("t3_idle", 64'(busy), 64'd0);

        // timeout, then a normal job
        never_done = 1'b1;
        send(5, 1, 1);
        get_rsp("t4_to", 0, 1, 8, w);
        never_done = 1'b0;
        send(1, 2, 3);
        get_rsp("t4_next", 5, 0, 2, w);

        // reset in the middle of WAIT
        send(50, 1, 1);
        repeat (3) @(negedge clk);
        check("t5_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t5_k_r_enable", 64'(k_r_enable), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        send(1, 4, 4);
        get_rsp("t5_next", 8, 0, 2, w);

        // done on the exact timeout cycle
        send(7, 3, 4);
        get_rsp("t6", 7, 0, 8, w);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
